// File: rtl/alu_ctl_stage.sv
// alu_ctl_stage
// Issue-side partner of the combinational ALU. Decodes aluop/funct/opcode
// into the ALU's 4-bit ctl code, selects the a/b operands and presents them
// from a single registered valid/ready pipeline stage (1-cycle latency,
// full throughput on back-to-back accepts). Undecodable ops are passed
// downstream with ctl=4'b1111 and illegal=1 so the core can trap them.
//
// Optional build macro: ALU_CTL_STATS_EN
//   defined   -> illegal_count counts accepted, non-flushed illegal ops
//                (saturating at 16'hFFFF, cleared only by reset)
//   undefined -> illegal_count is tied to zero and no counter is built
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready = ~out_valid | out_ready)
//   aluop, funct,      decode inputs
//   opcode, alusrc
//   rs_data, rt_data,  operand sources
//   imm
//   flush              kills the stage contents and any same-cycle input
//   out_valid/out_ready downstream handshake to the EX stage
//   ctl, a, b, illegal registered ALU control/operands and decode fault
//   illegal_count      illegal-op statistics counter (see macro above)

module alu_ctl_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [5:0]        opcode,
  input  logic              alusrc,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [3:0]        ctl,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              illegal,
  output logic [15:0]       illegal_count
);

  logic              accept;
  logic [3:0]        dec_ctl;
  logic              dec_illegal;
  logic              dec_zext;
  logic [DATA_W-1:0] ext_imm;
  logic [DATA_W-1:0] b_next;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Decode aluop/funct/opcode into the ALU control code. Only the logical
  // I-type ops (andi/ori/xori) zero-extend their immediate; everything else,
  // including R-type with alusrc=1, sign-extends.
  always_comb begin
    dec_ctl     = 4'b1111;
    dec_illegal = 1'b0;
    dec_zext    = 1'b0;
    unique case (aluop)
      2'b00: dec_ctl = 4'b0010;
      2'b01: dec_ctl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: dec_ctl = 4'b0010;
          6'b100010, 6'b100011: dec_ctl = 4'b0110;
          6'b100100:            dec_ctl = 4'b0000;
          6'b100101:            dec_ctl = 4'b0001;
          6'b100110:            dec_ctl = 4'b1101;
          6'b100111:            dec_ctl = 4'b1100;
          6'b101010:            dec_ctl = 4'b0111;
          default:              dec_illegal = 1'b1;
        endcase
      end
      default: begin
        case (opcode)
          6'b001000, 6'b001001: dec_ctl = 4'b0010;
          6'b001010:            dec_ctl = 4'b0111;
          6'b001100: begin dec_ctl = 4'b0000; dec_zext = 1'b1; end
          6'b001101: begin dec_ctl = 4'b0001; dec_zext = 1'b1; end
          6'b001110: begin dec_ctl = 4'b1101; dec_zext = 1'b1; end
          default:              dec_illegal = 1'b1;
        endcase
      end
    endcase
    if (dec_illegal) dec_ctl = 4'b1111;
  end

  assign ext_imm = dec_zext ? {{(DATA_W-IMM_W){1'b0}}, imm}
                            : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign b_next  = alusrc ? ext_imm : rt_data;

  // Pipeline register. Flush outranks a load; a retire without a new load
  // only drops valid so ctl/a/b stay on their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      ctl       <= 4'b0000;
      a         <= '0;
      b         <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctl       <= dec_ctl;
      a         <= rs_data;
      b         <= b_next;
      illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_CTL_STATS_EN
  logic [15:0] illegal_cnt;

  // Saturating count of illegal ops that actually made it into the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= 16'h0000;
    end else if (accept && dec_illegal && !flush && illegal_cnt != 16'hFFFF) begin
      illegal_cnt <= illegal_cnt + 16'h0001;
    end
  end

  assign illegal_count = illegal_cnt;
`else
  assign illegal_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_ctl_stage.sv
// tb_alu_ctl_stage
// Directed self-checking bench for alu_ctl_stage. Each scenario task drives
// its own stimulus and compares registered outputs #1 after the clock edge
// against hand-computed values.

module tb_alu_ctl_stage;

`ifdef ALU_CTL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic        alusrc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic        illegal;
  logic [15:0] illegal_count;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = 16'h0000;

  alu_ctl_stage #(.DATA_W(32), .IMM_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .opcode(opcode), .alusrc(alusrc),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .ctl(ctl), .a(a), .b(b),
    .illegal(illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction onto the input side.
  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [5:0] fn, input logic [5:0] opc,
                               input logic src, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [15:0] im);
    in_valid = v; aluop = op; funct = fn; opcode = opc;
    alusrc = src; rs_data = rs; rt_data = rt; imm = im;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctl: got %b expected 0000", ctl); end
    checks++; if (a !== 32'h0 || b !== 32'h0) begin errors++; $display("[TB] FAIL reset_ab: got a=%h b=%h expected 0", a, b); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
    checks++; if (illegal_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0000", illegal_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0]  fn_tab  [6] = '{6'b100110, 6'b101010, 6'b100011, 6'b100111, 6'b100001, 6'b100101};
    logic [3:0]  ctl_tab [6] = '{4'b1101,   4'b0111,   4'b0110,   4'b1100,   4'b0010,   4'b0001};
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 6'b100100, 6'b000000, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 16'h0);
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL and_valid: got %b expected 1", out_valid); end
    checks++; if (ctl !== 4'b0000) begin errors++; $display("[TB] FAIL and_ctl: got %b expected 0000", ctl); end
    checks++; if (a !== 32'hF0F0_F0F0) begin errors++; $display("[TB] FAIL and_a: got %h expected f0f0f0f0", a); end
    checks++; if (b !== 32'h0FF0_0FF0) begin errors++; $display("[TB] FAIL and_b: got %h expected 0ff00ff0", b); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL and_illegal: got %b expected 0", illegal); end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b10, fn_tab[i], 6'b000000, 1'b0, 32'h100 + i, 32'h200 + i, 16'h0);
      step();
      checks++; if (ctl !== ctl_tab[i] || b !== 32'h200 + i) begin errors++; $display("[TB] FAIL rtype_%0d: got ctl=%b b=%h expected ctl=%b b=%h", i, ctl, b, ctl_tab[i], 32'h200 + i); end
    end
    applyStimulus(1'b1, 2'b00, 6'b111111, 6'b111111, 1'b0, 32'h1, 32'h2, 16'h0);
    step();
    checks++; if (ctl !== 4'b0010 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL aluop00: got ctl=%b ill=%b expected 0010/0", ctl, illegal); end
    applyStimulus(1'b1, 2'b01, 6'b111111, 6'b111111, 1'b0, 32'h1, 32'h2, 16'h0);
    step();
    checks++; if (ctl !== 4'b0110 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL aluop01: got ctl=%b ill=%b expected 0110/0", ctl, illegal); end
  endtask

  task automatic test_itype();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 6'b000000, 6'b001101, 1'b1, 32'h5, 32'hDEAD_BEEF, 16'h8001);
    step();
    checks++; if (ctl !== 4'b0001 || b !== 32'h0000_8001) begin errors++; $display("[TB] FAIL ori: got ctl=%b b=%h expected 0001/00008001", ctl, b); end
    applyStimulus(1'b1, 2'b11, 6'b000000, 6'b001010, 1'b1, 32'h5, 32'hDEAD_BEEF, 16'h8001);
    step();
    checks++; if (ctl !== 4'b0111 || b !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL slti: got ctl=%b b=%h expected 0111/ffff8001", ctl, b); end
    applyStimulus(1'b1, 2'b11, 6'b000000, 6'b001110, 1'b1, 32'h5, 32'hDEAD_BEEF, 16'hC000);
    step();
    checks++; if (ctl !== 4'b1101 || b !== 32'h0000_C000) begin errors++; $display("[TB] FAIL xori: got ctl=%b b=%h expected 1101/0000c000", ctl, b); end
    applyStimulus(1'b1, 2'b11, 6'b000000, 6'b001001, 1'b1, 32'h5, 32'hDEAD_BEEF, 16'hFFFE);
    step();
    checks++; if (ctl !== 4'b0010 || b !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL addiu: got ctl=%b b=%h expected 0010/fffffffe", ctl, b); end
    applyStimulus(1'b1, 2'b10, 6'b100000, 6'b001100, 1'b1, 32'h5, 32'hDEAD_BEEF, 16'h8001);
    step();
    checks++; if (ctl !== 4'b0010 || b !== 32'hFFFF_8001) begin errors++; $display("[TB] FAIL rtype_imm: got ctl=%b b=%h expected 0010/ffff8001", ctl, b); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 6'b100101, 6'b000000, 1'b0, 32'h11, 32'h22, 16'h0);
    step();
    applyStimulus(1'b1, 2'b10, 6'b100010, 6'b000000, 1'b0, 32'h33, 32'h44, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || ctl !== 4'b0001 || a !== 32'h11 || b !== 32'h22) begin
        errors++; $display("[TB] FAIL hold_%0d: got rdy=%b v=%b ctl=%b a=%h b=%h expected 0/1/0001/11/22", i, in_ready, out_valid, ctl, a, b);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || ctl !== 4'b0110 || a !== 32'h33 || b !== 32'h44) begin
      errors++; $display("[TB] FAIL release_load: got v=%b ctl=%b a=%h b=%h expected 1/0110/33/44", out_valid, ctl, a, b);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'b00, 6'b000000, 6'b000000, 1'b0, 32'h1000 + i, 32'h2000 + i, 16'h0);
      step();
      checks++; if (out_valid !== 1'b1 || a !== 32'h1000 + i) begin errors++; $display("[TB] FAIL stream_%0d: got v=%b a=%h expected 1/%h", i, out_valid, a, 32'h1000 + i); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || a !== 32'h1007 || b !== 32'h2007) begin
      errors++; $display("[TB] FAIL retire: got v=%b a=%h b=%h expected 0/1007/2007", out_valid, a, b);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 6'b001000, 6'b000000, 1'b0, 32'h7, 32'h8, 16'h0);
    step();
    if (STATS) exp_count = exp_count + 16'h1;
    checks++; if (out_valid !== 1'b1 || ctl !== 4'b1111 || illegal !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_funct: got v=%b ctl=%b ill=%b expected 1/1111/1", out_valid, ctl, illegal);
    end
    checks++; if (illegal_count !== exp_count) begin errors++; $display("[TB] FAIL illegal_count1: got %h expected %h", illegal_count, exp_count); end
    applyStimulus(1'b1, 2'b11, 6'b100000, 6'b000000, 1'b1, 32'h7, 32'h8, 16'h1);
    step();
    if (STATS) exp_count = exp_count + 16'h1;
    checks++; if (ctl !== 4'b1111 || illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_opcode: got ctl=%b ill=%b expected 1111/1", ctl, illegal); end
    checks++; if (illegal_count !== exp_count) begin errors++; $display("[TB] FAIL illegal_count2: got %h expected %h", illegal_count, exp_count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    flush = 1'b1;
    applyStimulus(1'b1, 2'b10, 6'b111111, 6'b000000, 1'b0, 32'h9, 32'hA, 16'h0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("[TB] FAIL flush: got v=%b ill=%b expected 0/0", out_valid, illegal); end
    checks++; if (illegal_count !== exp_count) begin errors++; $display("[TB] FAIL flush_count: got %h expected %h", illegal_count, exp_count); end
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 6'b100111, 6'b000000, 1'b0, 32'hAB, 32'hCD, 16'h0);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || ctl !== 4'b1100) begin errors++; $display("[TB] FAIL prereset_hold: got v=%b ctl=%b expected 1/1100", out_valid, ctl); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 16'h0;
    checks++; if (out_valid !== 1'b0 || ctl !== 4'b0000 || a !== 32'h0 || b !== 32'h0 || illegal !== 1'b0 || illegal_count !== 16'h0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_hold: got v=%b ctl=%b a=%h b=%h ill=%b cnt=%h rdy=%b expected all reset values", out_valid, ctl, a, b, illegal, illegal_count, in_ready);
    end
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 6'b000000, 6'b111111, 1'b0, 32'h1, 32'h2, 16'h0);
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_count = STATS ? 16'hFFFF : 16'h0000;
    checks++; if (illegal_count !== exp_count) begin errors++; $display("[TB] FAIL saturate: got %h expected %h", illegal_count, exp_count); end
    step();
    checks++; if (illegal_count !== exp_count) begin errors++; $display("[TB] FAIL saturate_hold: got %h expected %h", illegal_count, exp_count); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 6'b0, 6'b0, 1'b0, 32'h0, 32'h0, 16'h0);
    test_reset();
    test_rtype();
    test_itype();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_hold();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctl_stage.md
Name: alu_ctl_stage

Overview:
- Issue-side partner of the combinational ALU: decodes ALUOp/funct/opcode into the ALU's 4-bit ctl code and selects the a/b operands.
- Presents ctl, a and b from a registered, valid/ready-handshaked pipeline stage; the ALU consumes these outputs directly in the EX stage.
- Flags undecodable instructions so the core can trap them.

Parameters:
- DATA_W, 32, operand width (a, b, rs_data, rt_data).
- IMM_W, 16, immediate width before extension.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a decoded instruction
- in_ready  output  1  stage can accept this cycle
- aluop  input  2  00 add, 01 sub, 10 R-type (use funct), 11 I-type ALU (use opcode)
- funct  input  6  R-type funct field
- opcode  input  6  instruction opcode
- alusrc  input  1  1: b from extended imm; 0: b from rt_data
- rs_data  input  DATA_W  register rs value
- rt_data  input  DATA_W  register rt value
- imm  input  IMM_W  immediate field
- flush  input  1  kill stage contents (branch/exception)
- out_ready  input  1  EX stage can take the held op
- out_valid  output  1  held op is valid
- ctl  output  4  ALU control code
- a  output  DATA_W  ALU operand a
- b  output  DATA_W  ALU operand b
- illegal  output  1  held op failed to decode
- illegal_count  output  16  illegal-op counter; see Optional Feature

Behaviour:
- Reset (sync, highest priority): out_valid=0, ctl=4'b0000, a=0, b=0, illegal=0, illegal_count=0.
- in_ready = ~out_valid | out_ready (combinational). Accept = in_valid & in_ready.
- Load on accept: ctl, a=rs_data, b, illegal registered. out_valid=1 on the next edge; latency is 1 cycle.
- Hold when out_valid & ~out_ready: all outputs stable, in_ready=0.
- Retire without load (out_valid & out_ready & ~in_valid): out_valid=0. ctl/a/b keep their last values.
- Flush beats load: on a flush cycle, next out_valid=0, any same-cycle input is dropped, and illegal=0. in_ready still follows its formula, so the upstream sees the input as accepted and discarded.
- Decode when aluop=00: ctl=0010. aluop=01: ctl=0110.
- Decode when aluop=10 (funct):
  - 100000/100001 -> 0010
  - 100010/100011 -> 0110
  - 100100 -> 0000
  - 100101 -> 0001
  - 100110 -> 1101
  - 100111 -> 1100
  - 101010 -> 0111
  - any other funct -> illegal
- Decode when aluop=11 (opcode):
  - 001000/001001 -> 0010, sign-extend
  - 001010 -> 0111, sign-extend
  - 001100 -> 0000, zero-extend
  - 001101 -> 0001, zero-extend
  - 001110 -> 1101, zero-extend
  - any other opcode -> illegal
- Illegal: ctl=4'b1111 (ALU returns 0 for this code), illegal=1. The op is still passed downstream with out_valid=1.
- Operand b: alusrc ? ext(imm) : rt_data.
  - ext is zero-extend only for opcodes 001100/001101/001110 under aluop=11; sign-extend in all other cases.
  - alusrc=1 with aluop=10 is legal and uses sign-extend.
- No internal FSM beyond the valid bit. There are no bubbles on back-to-back accepts, giving full throughput.

Optional Feature:
- Macro: ALU_CTL_STATS_EN.
- Defined: illegal_count increments by 1 on each accepted illegal op that is not flushed in that same cycle. It saturates at 16'hFFFF and clears only on reset.
- Undefined: illegal_count is tied to 16'h0000 and no counter flops are built. Port list is identical in both builds.

Test Plan:
- Reset, then aluop=10, funct=100100, rs=32'hF0F0_F0F0, rt=32'h0FF0_0FF0, alusrc=0, out_ready=1 -> next cycle out_valid=1, ctl=0000, a=F0F0_F0F0, b=0FF0_0FF0, illegal=0.
- aluop=11, opcode=001101, imm=16'h8001, alusrc=1 -> ctl=0001, b=32'h0000_8001. Repeat with opcode=001010 -> ctl=0111, b=32'hFFFF_8001.
- Hold out_ready=0 with in_valid=1 for 3 cycles after one accept -> in_ready=0, outputs stable. Then raise out_ready -> next op loads the following cycle with no bubble. Stream 8 ops back-to-back with out_ready=1 -> out_valid stays 1 for 8 consecutive cycles.
- aluop=10, funct=001000 -> ctl=1111, illegal=1, out_valid=1. With ALU_CTL_STATS_EN, illegal_count=1; without it, 0.
- flush=1 in the same cycle as an accepted illegal op -> next out_valid=0, illegal=0, illegal_count unchanged.
- Assert reset while out_valid=1 and out_ready=0 -> next cycle all outputs equal reset values and in_ready=1. With ALU_CTL_STATS_EN, force 65536 illegal accepts -> illegal_count=FFFF.
